// File: rtl/oversampled_cdr_if.sv
// Bundle of the sample stream into the CDR and the recovered-bit stream out of it.
//   Sample_in    : W-bit quantized channel sample (unsigned code)
//   Sample_valid : Sample_in is valid this cycle; low means the whole CDR stalls
//   Data_out     : recovered bit
//   Data_valid   : one-cycle strobe marking Data_out as valid
//   Locked       : CDR is in the LOCKED state
//   Edge_phase   : tracked edge position within the UI
// master = sample source / data consumer, slave = the CDR.
interface oversampled_cdr_if #(
  parameter int N = 10,
  parameter int W = 8
);
  logic [W-1:0]         Sample_in;
  logic                 Sample_valid;
  logic                 Data_out;
  logic                 Data_valid;
  logic                 Locked;
  logic [$clog2(N)-1:0] Edge_phase;

  modport master (
    output Sample_in, Sample_valid,
    input  Data_out, Data_valid, Locked, Edge_phase
  );

  modport slave (
    input  Sample_in, Sample_valid,
    output Data_out, Data_valid, Locked, Edge_phase
  );
endinterface

// File: rtl/oversampled_cdr.sv
// Oversampled clock-and-data recovery. Each channel code is sliced with
// hysteresis, transitions are located on an N-phase counter, the tracked edge
// position steers a mid-eye sample phase, and one recovered bit per UI is
// emitted with a strobe. An ACQUIRE/TRACK/LOCKED FSM decides how hard the
// edge position follows observed transitions.
// Ports:
//   Sample_CLK : sample clock, all logic on its rising edge
//   Rst        : synchronous active-high reset
//   bus        : slave side of oversampled_cdr_if (samples in, bits/status out)
// N must be even and >= 4; THRESH must be >= HYST.
module oversampled_cdr #(
  parameter int N          = 10,
  parameter int W          = 8,
  parameter int THRESH     = 128,
  parameter int HYST       = 4,
  parameter int LOCK_COUNT = 8,
  parameter int MISS_LIMIT = 4
) (
  input  logic             Sample_CLK,
  input  logic             Rst,
  oversampled_cdr_if.slave bus
);
  localparam int PW = $clog2(N);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);

  localparam logic [W:0]    HI_CODE = (W+1)'(THRESH + HYST);
  localparam logic [W:0]    LO_CODE = (W+1)'(THRESH - HYST);
  localparam logic [PW-1:0] PH_LAST = PW'(N - 1);
  localparam logic [PW-1:0] HALF    = PW'(N / 2);
  // Truncates to 0 when N is a power of two; the phase arithmetic is then
  // naturally modulo N, so the wrap-around formula below still holds.
  localparam logic [PW-1:0] N_MOD   = PW'(N);

  typedef enum logic [1:0] {ACQUIRE, TRACK, LOCKED} state_t;

  state_t        state;
  logic          slice_bit;
  logic [PW-1:0] ph;
  logic [PW-1:0] edge_pos;
  logic [GW-1:0] good_cnt;
  logic [MW-1:0] miss_cnt;
  logic          data_out;
  logic          data_valid;
  logic          locked;

  logic          slice_next;
  logic          edge_hit;
  logic          in_window;
  logic          toward_up;
  logic          fire;
  logic [W:0]    code;
  logic [PW-1:0] ph_next;
  logic [PW-1:0] diff;
  logic [PW-1:0] samp_ph;
  logic [PW-1:0] pos_up;
  logic [PW-1:0] pos_dn;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    code       = {1'b0, bus.Sample_in};
    slice_next = slice_bit;
    if (code >= HI_CODE) begin
      slice_next = 1'b1;
    end else if (code <= LO_CODE) begin
      slice_next = 1'b0;
    end
    edge_hit = (slice_next != slice_bit);

    ph_next = (ph == PH_LAST) ? '0 : ph + 1'b1;

    // (ph - edge_pos) mod N in 0..N-1; 0..N/2 reads as non-negative (the tie
    // N/2 counts as +N/2), N/2+1..N-1 as negative.
    if (ph >= edge_pos) begin
      diff = ph - edge_pos;
    end else begin
      diff = ph + N_MOD - edge_pos;
    end
    in_window = (diff <= PW'(1)) || (diff == PH_LAST);
    toward_up = (diff <= HALF);

    pos_up = (edge_pos == PH_LAST) ? '0 : edge_pos + 1'b1;
    pos_dn = (edge_pos == '0) ? PH_LAST : edge_pos - 1'b1;

    // Mid-eye phase derived from the current (pre-update) edge position.
    samp_ph = (edge_pos >= HALF) ? edge_pos - HALF : edge_pos + HALF;
    fire    = bus.Sample_valid && (state != ACQUIRE) && (ph == samp_ph);
  end

  // NOTE: Rst is sampled only on the clock edge; every state register,
  // including the outputs, returns to its idle value.
  // NOTE: registers use non-blocking assignments so all updates in this block
  // see the pre-edge values, e.g. the sample phase uses the old edge_pos.
  always_ff @(posedge Sample_CLK) begin
    if (Rst) begin
      state      <= ACQUIRE;
      slice_bit  <= 1'b0;
      ph         <= '0;
      edge_pos   <= '0;
      good_cnt   <= '0;
      miss_cnt   <= '0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      locked     <= 1'b0;
    end else if (!bus.Sample_valid) begin
      data_valid <= 1'b0;
    end else begin
      slice_bit  <= slice_next;
      ph         <= ph_next;
      data_valid <= fire;
      if (fire) begin
        data_out <= slice_bit;
      end

      if (edge_hit) begin
        unique case (state)
          ACQUIRE: begin
            edge_pos <= ph;
            good_cnt <= '0;
            state    <= TRACK;
            locked   <= 1'b0;
          end
          TRACK: begin
            if (in_window) begin
              // Stepping by d from edge_pos lands exactly on ph.
              edge_pos <= ph;
              if (good_cnt != GW'(LOCK_COUNT)) begin
                good_cnt <= good_cnt + 1'b1;
              end
              if (good_cnt >= GW'(LOCK_COUNT - 1)) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end else begin
              edge_pos <= toward_up ? pos_up : pos_dn;
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (in_window) begin
              edge_pos <= ph;
              miss_cnt <= '0;
            end else if (miss_cnt >= MW'(MISS_LIMIT - 1)) begin
              state    <= TRACK;
              locked   <= 1'b0;
              good_cnt <= '0;
              miss_cnt <= '0;
            end else begin
              miss_cnt <= miss_cnt + 1'b1;
            end
          end
          default: begin
            state  <= ACQUIRE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Data_out   = data_out;
  assign bus.Data_valid = data_valid;
  assign bus.Locked     = locked;
  assign bus.Edge_phase = edge_pos;
endmodule

// File: tb/tb_oversampled_cdr.sv
// Directed bench for oversampled_cdr (N=10, W=8, THRESH=128, HYST=4,
// LOCK_COUNT=8, MISS_LIMIT=4). Stimulus is clean 0/255 square waves whose
// transitions are placed on chosen phases, plus a hand-written hysteresis
// sequence. Expected edge positions and lock states come from hand-derived
// tables; strobe timing is checked against the mid-eye phase of the expected
// edge position, and strobed data against the level driven one sample earlier.
module tb_oversampled_cdr;
  localparam int N = 10;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  oversampled_cdr_if #(.N(N), .W(W)) bus ();

  oversampled_cdr #(
    .N(N), .W(W), .THRESH(128), .HYST(4), .LOCK_COUNT(8), .MISS_LIMIT(4)
  ) dut (
    .Sample_CLK (clk),
    .Rst        (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;

  // Bench-side view of the stream.
  int   nxt_ph;   // phase the DUT will use for the next valid sample
  logic cur_lvl;  // level of the most recent valid sample
  logic prev_lvl; // level of the valid sample before that
  int   tb_ep;    // expected edge position
  logic tb_acq;   // expected to still be in ACQUIRE

  task automatic step(input logic [7:0] code, input logic valid);
    bus.Sample_in    = code;
    bus.Sample_valid = valid;
    @(posedge clk);
    #1;
    if (valid) nxt_ph = (nxt_ph + 1) % N;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bus.Sample_valid = 1'b0;
    bus.Sample_in    = 8'd0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    nxt_ph   = 0;
    cur_lvl  = 1'b0;
    prev_lvl = 1'b0;
    tb_ep    = 0;
    tb_acq   = 1'b1;
  endtask

  // Drive a square wave that toggles whenever the sample phase equals p
  // (p < 0: never toggles). Runs until n_edges toggles (or max_samples when
  // n_edges is 0). After each toggle Edge_phase/Locked are checked against
  // exp_ep/exp_lock; every cycle the strobe and strobed data are checked.
  task automatic run_edges(input int p, input int n_edges, input int exp_ep,
                           input logic exp_lock, input int max_samples);
    int   edges = 0;
    int   cnt   = 0;
    int   sp;
    int   ph_now;
    logic toggle;
    logic exp_dv;
    while (cnt < max_samples && (n_edges == 0 || edges < n_edges)) begin
      ph_now   = nxt_ph;
      toggle   = (ph_now == p);
      prev_lvl = cur_lvl;
      if (toggle) cur_lvl = ~cur_lvl;
      sp     = (tb_ep + N / 2) % N;
      exp_dv = !tb_acq && (ph_now == sp);
      step(cur_lvl ? 8'd255 : 8'd0, 1'b1);
      cnt++;
      n_tests++;
      if (bus.Data_valid !== exp_dv) begin
        n_fail++;
        $display("FAIL strobe ph=%0d: Data_valid=%b expected %b", ph_now, bus.Data_valid, exp_dv);
      end
      if (exp_dv) begin
        n_tests++;
        if (bus.Data_out !== prev_lvl) begin
          n_fail++;
          $display("FAIL data ph=%0d: Data_out=%b expected %b", ph_now, bus.Data_out, prev_lvl);
        end
      end
      if (toggle) begin
        edges++;
        tb_ep  = exp_ep;
        tb_acq = 1'b0;
        n_tests++;
        if (bus.Edge_phase !== 4'(exp_ep)) begin
          n_fail++;
          $display("FAIL edge_phase edge@%0d: got %0d expected %0d", ph_now, bus.Edge_phase, exp_ep);
        end
        n_tests++;
        if (bus.Locked !== exp_lock) begin
          n_fail++;
          $display("FAIL locked edge@%0d: got %b expected %b", ph_now, bus.Locked, exp_lock);
        end
      end
    end
    if (n_edges > 0 && edges < n_edges) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_timeout p=%0d: saw %0d edges, expected %0d", p, edges, n_edges);
    end
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus.Sample_valid = 1'b1;
    bus.Sample_in    = 8'd255;
    repeat (2) @(posedge clk);
    #1;
    n_tests += 4;
    if (bus.Data_out   !== 1'b0) begin n_fail++; $display("FAIL reset_data_out: got %b expected 0", bus.Data_out); end
    if (bus.Data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b expected 0", bus.Data_valid); end
    if (bus.Locked     !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", bus.Locked); end
    if (bus.Edge_phase !== 4'd0) begin n_fail++; $display("FAIL reset_edge_phase: got %0d expected 0", bus.Edge_phase); end
  endtask

  task automatic test_hysteresis();
    int   h_code [11] = '{0, 130, 131, 132, 133, 125, 131, 126, 130, 127, 124};
    int   h_ep   [11] = '{0, 0,   0,   3,   3,   3,   3,   3,   3,   3,   2};
    logic h_dv   [11] = '{0, 0,   0,   0,   0,   0,   0,   0,   1,   0,   0};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(8'(h_code[i]), 1'b1);
      n_tests += 2;
      if (bus.Edge_phase !== 4'(h_ep[i])) begin
        n_fail++;
        $display("FAIL hyst_edge_phase code=%0d: got %0d expected %0d", h_code[i], bus.Edge_phase, h_ep[i]);
      end
      if (bus.Data_valid !== h_dv[i]) begin
        n_fail++;
        $display("FAIL hyst_strobe code=%0d: got %b expected %b", h_code[i], bus.Data_valid, h_dv[i]);
      end
      if (h_dv[i]) begin
        n_tests++;
        if (bus.Data_out !== 1'b1) begin
          n_fail++;
          $display("FAIL hyst_data: got %b expected 1", bus.Data_out);
        end
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    run_edges(3, 1, 3, 1'b0, 20);
    run_edges(3, 7, 3, 1'b0, 100);
    run_edges(3, 1, 3, 1'b1, 20);
    run_edges(3, 3, 3, 1'b1, 40);
  endtask

  task automatic test_drift();
    run_edges(4, 3, 4, 1'b1, 50);
    run_edges(5, 3, 5, 1'b1, 50);
    run_edges(4, 1, 4, 1'b1, 50);
    run_edges(3, 2, 3, 1'b1, 50);
  endtask

  task automatic test_loss_of_lock();
    int   l_ep [16] = '{3, 3, 3, 3, 4, 5, 6, 7, 8, 8, 8, 8, 8, 8, 8, 8};
    logic l_lk [16] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 16; i++) begin
      run_edges(8, 1, l_ep[i], l_lk[i], 20);
    end
  endtask

  task automatic test_stall();
    // Stop just before the mid-eye phase (3) so the first resumed cycle strobes.
    run_edges(-1, 0, 0, 1'b1, 4);
    for (int i = 0; i < 7; i++) begin
      step(cur_lvl ? 8'd0 : 8'd255, 1'b0);
      n_tests += 3;
      if (bus.Data_valid !== 1'b0) begin n_fail++; $display("FAIL stall_strobe cyc=%0d: got %b expected 0", i, bus.Data_valid); end
      if (bus.Edge_phase !== 4'd8) begin n_fail++; $display("FAIL stall_edge_phase cyc=%0d: got %0d expected 8", i, bus.Edge_phase); end
      if (bus.Locked !== 1'b1)     begin n_fail++; $display("FAIL stall_locked cyc=%0d: got %b expected 1", i, bus.Locked); end
    end
    run_edges(8, 2, 8, 1'b1, 30);
  endtask

  task automatic test_reset_mid();
    n_tests++;
    if (bus.Locked !== 1'b1) begin n_fail++; $display("FAIL premid_locked: got %b expected 1", bus.Locked); end
    rst              = 1'b1;
    bus.Sample_valid = 1'b1;
    bus.Sample_in    = 8'd255;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    nxt_ph   = 0;
    cur_lvl  = 1'b0;
    prev_lvl = 1'b0;
    tb_ep    = 0;
    tb_acq   = 1'b1;
    n_tests += 4;
    if (bus.Data_out   !== 1'b0) begin n_fail++; $display("FAIL mid_data_out: got %b expected 0", bus.Data_out); end
    if (bus.Data_valid !== 1'b0) begin n_fail++; $display("FAIL mid_data_valid: got %b expected 0", bus.Data_valid); end
    if (bus.Locked     !== 1'b0) begin n_fail++; $display("FAIL mid_locked: got %b expected 0", bus.Locked); end
    if (bus.Edge_phase !== 4'd0) begin n_fail++; $display("FAIL mid_edge_phase: got %0d expected 0", bus.Edge_phase); end
    // No strobes without an edge; the next edge is acquired directly.
    run_edges(-1, 0, 0, 1'b0, 15);
    run_edges(6, 1, 6, 1'b0, 20);
    run_edges(-1, 0, 0, 1'b0, 12);
  endtask

  initial begin
    bus.Sample_in    = 8'd0;
    bus.Sample_valid = 1'b0;
    nxt_ph   = 0;
    cur_lvl  = 1'b0;
    prev_lvl = 1'b0;
    tb_ep    = 0;
    tb_acq   = 1'b1;
    test_reset();
    test_hysteresis();
    test_lock();
    test_drift();
    test_loss_of_lock();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
